// File: rtl/mem_reader_pkg.sv
// Shared types and constants for the sequential burst reader.
package mem_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mem_reader_fifo2.sv
// Two-entry output buffer; head is presented combinationally, push and pop may coincide.
module mem_reader_fifo2
   import mem_reader_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [1:0]        occ,
   output logic [DATA_W-1:0] head,
   output logic              valid
);

   logic [1:0][DATA_W-1:0] entry;
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic [1:0]             count;
   logic                   full;
   logic                   push_ok;
   logic                   pop_ok;

   assign full    = (count == 2'(FIFO_DEPTH));
   assign valid   = (count != 2'd0);
   assign pop_ok  = pop && valid;
   assign push_ok = push && (!full || pop_ok);
   assign occ     = count;
   assign head    = entry[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entry  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            entry[wr_ptr] <= wdata;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_reader.sv
// Burst reader: streams `length` words from base_addr out of a 1-cycle-latency sync memory.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for start; base/length latched on start
//  ST_READ  | issuing reads while the 2-word credit allows
//  ST_DRAIN | all reads issued, waiting for the last word to be accepted
//  ST_DONE  | one-cycle done pulse, then back to idle
module mem_reader
   import mem_reader_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   issued;
   logic [ADDR_W:0]   accepted;
   logic              inflight;
   logic [1:0]        occ;
   logic              pop;
   logic              credit_ok;
   logic              issue_last;
   logic              pop_last;

   assign pop        = out_valid && out_ready;
   // Buffer space is reserved for the word still in flight from memory.
   assign credit_ok  = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
   assign issue_last = ((issued + CNT_ONE) == len);
   assign pop_last   = pop && ((accepted + CNT_ONE) == len);
   assign mem_addr   = addr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (length == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (mem_en && issue_last) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop_last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != ST_IDLE);
      done   = (state == ST_DONE);
      mem_en = (state == ST_READ) && credit_ok;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr     <= '0;
         len      <= '0;
         issued   <= '0;
         accepted <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= mem_en;
         if (state == ST_IDLE) begin
            if (start) begin
               addr     <= base_addr;
               len      <= length;
               issued   <= '0;
               accepted <= '0;
            end
         end else begin
            if (mem_en) begin
               addr   <= addr + ADDR_W'(1);
               issued <= issued + CNT_ONE;
            end
            if (pop) begin
               accepted <= accepted + CNT_ONE;
            end
         end
      end
   end

   mem_reader_fifo2 #(
      .DATA_W(DATA_W)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (inflight),
      .wdata(mem_rdata),
      .pop  (pop),
      .occ  (occ),
      .head (out_data),
      .valid(out_valid)
   );

endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: sync RAM model plus a word-order/credit reference.
module tb_mem_reader;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk       = 1'b0;
   logic              reset     = 1'b0;
   logic              start     = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   length    = '0;
   logic              busy;
   logic              done;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b1;

   logic [DATA_W-1:0] ram [DEPTH];

   int checks = 0;
   int errors = 0;

   mem_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base_addr(base_addr),
      .length   (length),
      .busy     (busy),
      .done     (done),
      .mem_en   (mem_en),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic ready_for(input int mode, input int k);
      case (mode)
         1:       return (k == 0) || (((k - 1) % 3) == 0);
         2:       return ($urandom % 4) != 0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_mem_en"}, mem_en, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
   endtask

   // k counts cycles from the one in which start is presented (cycle E).
   task automatic run_burst(input int b, input int n, input int mode, input int inject_k,
                            input int abort_k, input int exp_first, input int exp_done,
                            output int done_k);
      int   pops, issues, first_pop, dones, pop_now;
      logic prev_stall;
      logic [DATA_W-1:0] prev_data;
      pops = 0; issues = 0; first_pop = -1; dones = 0; done_k = -1; prev_stall = 1'b0;
      prev_data = '0;
      @(posedge clk); #1;
      for (int k = 0; k < 200; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         start     = (k == 0) || (k == inject_k);
         base_addr = (k == 0) ? ADDR_W'(b) : ADDR_W'(9);
         length    = (k == 0) ? (ADDR_W+1)'(n) : (ADDR_W+1)'(3);
         out_ready = ready_for(mode, k);
         if (k == abort_k) begin
            reset = 1'b0;
            #1;
            chk_reset_outputs("abort");
            start = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("abort_no_done", done, 0);
               chk("abort_no_valid", out_valid, 0);
            end
            @(posedge clk); #1;
            reset = 1'b1;
            return;
         end
         @(negedge clk);
         if (k == 0) begin
            chk("idle_busy", busy, 0);
            chk("idle_mem_en", mem_en, 0);
         end
         if (k == 1) chk("busy_e1", busy, 1);
         pop_now = (out_valid && out_ready) ? 1 : 0;
         if (mem_en) begin
            chk("issue_cnt", issues < n, 1);
            chk("mem_addr", mem_addr, (b + issues) % DEPTH);
            chk("credit", (issues - pops - pop_now) < 2, 1);
            issues++;
         end
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
         end
         if (pop_now == 1) begin
            chk("word", out_data, 8'hA0 + ((b + pops) % DEPTH));
            if (first_pop < 0) first_pop = k;
            pops++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (done) begin
            dones++;
            if (done_k < 0) done_k = k;
         end
         if (done_k >= 0 && k == done_k + 1) begin
            chk("busy_fall", busy, 0);
            break;
         end
      end
      start = 1'b0;
      if (done_k < 0) chk("done_timeout", 0, 1);
      chk("pops", pops, n);
      chk("issues", issues, n);
      chk("dones", dones, 1);
      if (exp_first >= 0) chk("first_lat", first_pop, exp_first);
      if (exp_done >= 0) chk("done_lat", done_k, exp_done);
   endtask

   initial begin
      int dk;
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'hA0 + 8'(i);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("rst");
      @(posedge clk); #1;
      reset = 1'b1;

      run_burst(2, 4, 0, -1, -1, 3, 7, dk);
      run_burst(14, 4, 0, -1, -1, 3, 7, dk);
      run_burst(0, 6, 1, -1, -1, -1, -1, dk);
      run_burst(0, 0, 0, -1, -1, -1, -1, dk);
      chk("len0_done_lat", (dk >= 1) && (dk <= 2), 1);
      run_burst(5, 16, 0, -1, -1, 3, 19, dk);
      run_burst(1, 8, 0, 3, -1, 3, 11, dk);
      run_burst(4, 8, 0, -1, 4, -1, -1, dk);
      run_burst(3, 5, 0, -1, -1, 3, 8, dk);
      for (int r = 0; r < 8; r++) begin
         run_burst(int'($urandom % DEPTH), int'($urandom_range(0, 16)), 2, -1, -1, -1, -1, dk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
